riscv_mc_ctrl: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It sequences the shared ALU, register file, PC and the single unified memory port across FETCH/DECODE/EXEC/MEM/WB states. It drives the 2-bit `alu_op` consumed by `alu_control`, which turns it into the 4-bit ALU control using funct3/funct7. It sits between the instruction register and the datapath muxes.

---
 rtl/riscv_mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle main control FSM for the RV32I core (FETCH/DECODE/EXEC/MEM/WB).
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes enter an absorbing TRAP state.
module riscv_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_op_q;
  logic       w_legal;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // Opcode is only trustworthy in DECODE; later states use the latched copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_op_q <= 7'd0;
    else if (r_state == ST_DECODE)  r_op_q <= opcode;
  end

  always_comb begin
    case (opcode)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: w_legal = 1'b1;
      default:                                                     w_legal = 1'b0;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_set_illegal;

  assign w_set_illegal = (r_state == ST_DECODE) && !w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign state = r_state;

  // Next-state and output decode; reset forces every output low asynchronously
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;

    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
        if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          w_next = ST_TRAP;
`else
          w_next = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        case (r_op_q)
          OP_R: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b10;
            w_next    = ST_WB;
          end
          OP_IALU: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            w_next    = ST_WB;
          end
          OP_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            w_next    = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            w_next    = ST_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
            w_next    = ST_FETCH;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            w_next   = ST_WB;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (r_op_q == OP_STORE);
        if (mem_ready) w_next = (r_op_q == OP_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write = 1'b1;
        if (r_op_q == OP_LOAD)     wb_sel = 2'b01;
        else if (r_op_q == OP_JAL) wb_sel = 2'b10;
        w_next = ST_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: w_next = ST_TRAP;
`endif
      default: w_next = ST_FETCH;
    endcase

    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: per-instruction expected cycle traces
// are generated from the instruction class and replayed against the DUT.
module tb_riscv_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] state;

  riscv_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        q_mr[$];
  logic [6:0]  q_op[$];
  logic        q_z[$];
  logic [18:0] q_ex[$];

  wire [18:0] w_obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                       alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, state, illegal};

  function automatic logic [18:0] mk(input logic req, input logic we, input logic io,
      input logic irw, input logic pcw, input logic pcs, input logic [1:0] a,
      input logic [1:0] b, input logic [1:0] op, input logic rw, input logic [1:0] wb,
      input logic [2:0] st, input logic ill);
    return {req, we, io, irw, pcw, pcs, a, b, op, rw, wb, st, ill};
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic logic rnd_b();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] legal [7] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic mr, input logic [6:0] op, input logic z, input logic [18:0] e);
    q_mr.push_back(mr);
    q_op.push_back(op);
    q_z.push_back(z);
    q_ex.push_back(e);
  endtask

  task automatic push_wb(input logic [1:0] sel);
    push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,1,sel,3'd4,0));
  endtask

  // Expected trace for one instruction: fw fetch waits, mw memory waits, z in EXEC
  task automatic build_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++)
      push(1'b0, rnd_op(), rnd_b(), mk(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd0,0));
    push(1'b1, rnd_op(), rnd_b(), mk(1,0,0,1,1,0,2'd0,2'd1,2'd0,0,2'd0,3'd0,0));
    push(rnd_b(), op, rnd_b(), mk(0,0,0,0,0,0,2'd3,2'd2,2'd0,0,2'd0,3'd1,0));
    if (!is_legal(op)) return;
    case (op)
      OP_R: begin
        push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd1,2'd0,2'd2,0,2'd0,3'd2,0));
        push_wb(2'd0);
      end
      OP_IALU: begin
        push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd1,2'd2,2'd2,0,2'd0,3'd2,0));
        push_wb(2'd0);
      end
      OP_LUI: begin
        push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,2'd0,3'd2,0));
        push_wb(2'd0);
      end
      OP_BRANCH:
        push(rnd_b(), rnd_op(), z, mk(0,0,0,0,z,1,2'd1,2'd0,2'd1,0,2'd0,3'd2,0));
      OP_JAL: begin
        push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,1,1,2'd0,2'd0,2'd0,0,2'd0,3'd2,0));
        push_wb(2'd2);
      end
      default: begin
        logic st = (op == OP_STORE);
        push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd1,2'd2,2'd0,0,2'd0,3'd2,0));
        for (int i = 0; i <= mw; i++)
          push(i == mw, rnd_op(), rnd_b(), mk(1,st,1,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd3,0));
        if (!st) push_wb(2'd1);
      end
    endcase
  endtask

  task automatic play(input string tag);
    logic [18:0] exp_v;
    while (q_ex.size() > 0) begin
      mem_ready = q_mr.pop_front();
      opcode    = q_op.pop_front();
      zero      = q_z.pop_front();
      exp_v     = q_ex.pop_front();
      #4;
      total++;
      if (w_obs !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, w_obs, exp_v);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic push_fetch_wait();
    push(1'b0, rnd_op(), rnd_b(), mk(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd0,0));
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      opcode = rnd_op();
      zero   = rnd_b();
      #4;
      total++;
      if (w_obs !== 19'd0) begin
        bad++;
        $display("FAIL reset_hold got=%h want=%h", w_obs, 19'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push_fetch_wait();
    play("reset_release");
  endtask

  task automatic test_rtype();
    build_instr(OP_R, 0, 0, rnd_b());
    play("rtype");
  endtask

  task automatic test_load_wait();
    build_instr(OP_LOAD, 0, 2, rnd_b());
    play("load_wait");
  endtask

  task automatic test_branch();
    build_instr(OP_BRANCH, 0, 0, 1'b1);
    play("branch_taken");
    build_instr(OP_BRANCH, 1, 0, 1'b0);
    play("branch_not_taken");
  endtask

  task automatic test_jal();
    build_instr(OP_JAL, 0, 0, rnd_b());
    play("jal");
  endtask

  task automatic test_illegal();
    build_instr(OP_BAD, 0, 0, rnd_b());
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      push(rnd_b(), rnd_op(), rnd_b(), mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd5,1));
    play("illegal_trap");
    rst = 1'b1;
    #2;
    total++;
    if (w_obs !== 19'd0) begin
      bad++;
      $display("FAIL trap_reset got=%h want=%h", w_obs, 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    push_fetch_wait();
    play("illegal_return");
  endtask

  task automatic test_reset_abort();
    build_instr(OP_STORE, 0, 0, 1'b0);
    void'(q_mr.pop_back()); void'(q_op.pop_back());
    void'(q_z.pop_back());  void'(q_ex.pop_back());
    play("abort_setup");
    mem_ready = 1'b0;
    #2;
    total++;
    if (w_obs !== mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd3,0)) begin
      bad++;
      $display("FAIL abort_mem got=%h want=%h", w_obs, mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd3,0));
    end
    rst = 1'b1;
    #1;
    total++;
    if (w_obs !== 19'd0) begin
      bad++;
      $display("FAIL abort_async got=%h want=%h", w_obs, 19'd0);
    end
    mem_ready = 1'b1;
    @(posedge clk); #2;
    total++;
    if (w_obs !== 19'd0) begin
      bad++;
      $display("FAIL abort_hold got=%h want=%h", w_obs, 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_fetch_wait();
    play("abort_release");
  endtask

  task automatic test_random();
    logic [6:0] legal [7] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    logic [6:0] op;
    for (int n = 0; n < 40; n++) begin
      op = legal[$urandom_range(6)];
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(7) == 0) begin
        op = rnd_op();
        while (is_legal(op)) op = rnd_op();
      end
`endif
      build_instr(op, $urandom_range(2), $urandom_range(3), rnd_b());
      play("random");
    end
    push_fetch_wait();
    play("random_end");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jal();
    test_reset_abort();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
